hazard_fwd_ctrl: RTL and testbench
==================================

# hazard_fwd_ctrl

Parametrised hazard and forwarding controller for the 5-stage pipeline (IF/ID/EX/MEM/WB). It supersedes purely combinational forwarding by keeping its own shadow pipeline of in-flight destination registers. From that shadow it pre-computes the EX forwarding selects one cycle early and registers them, generates load-use stalls and flush bubbles, freezes cleanly on multi-cycle data-memory accesses, and counts stall cycles. It sits beside the ID stage; the ID/EX, EX/MEM and MEM/WB registers consume its outputs.

## Interface
Parameters:
- REG_W, 4, register-address width (2^REG_W architectural registers)
- ZERO_REG, 1, when 1 register 0 is hardwired zero and never a hazard or forwarding source
- CNT_W, 16, stall-counter width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt, id_rd  in  REG_W each  ID source and destination fields
- id_rs_used, id_rt_used  in  1 each  source actually read
- id_reg_write, id_mem_to_reg, id_mem_write  in  1 each  ID control (mem_to_reg = load)
- flush  in  1  squash the ID instruction (branch taken or mispredict)
- mem_busy  in  1  data memory not done; freeze the whole pipeline
- pc_stall, ifid_stall  out  1 each  hold PC and IF/ID
- idex_bubble  out  1  load NOP into ID/EX
- fwd_a, fwd_b  out  2 each  EX operand selects: 00 regfile, 01 MEM/WB, 10 EX/MEM
- fwd_c  out  1  MEM store-data select: 1 takes MEM/WB write data
- stall_cnt  out  CNT_W  cycles with pc_stall=1, saturating

## Operation
- Shadow entries EX, MEM, WB each hold {valid, rd, reg_write, mem_to_reg, mem_write, rt}.
- "src matches entry" means: entry.valid, entry.reg_write, entry.rd == src, src used, and (ZERO_REG=0 or src != 0).
- Load-use (lu): the EX entry has mem_to_reg and matches id_rs, or matches id_rt. Exception: when id_mem_write=1 and only rt matches, there is no stall, because fwd_c covers that case.
- FSM states:
  - RUN: normal advance.
  - LU: one bubble cycle after a load-use.
  - FREEZE: mem_busy is high.
- FSM transitions:
  - RUN→LU when lu & !flush & !mem_busy.
  - LU→RUN unconditionally, unless mem_busy is high, in which case LU→FREEZE.
  - Any state→FREEZE when mem_busy is high.
  - FREEZE→RUN when mem_busy falls.
- Combinational outputs, in priority order:
  - mem_busy: pc_stall=ifid_stall=1, idex_bubble=0, all registered state holds.
  - flush: idex_bubble=1, stalls 0.
  - lu: pc_stall=ifid_stall=idex_bubble=1.
  - Otherwise all 0.
- Advance (when !mem_busy): WB←MEM, MEM←EX. EX←ID fields, but EX.valid=0 if idex_bubble or !id_valid.
- fwd_a and fwd_b are registered on advance, computed from the ID sources:
  - 10 if the source matches the current EX entry (which becomes EX/MEM).
  - else 01 if it matches the current MEM entry (which becomes MEM/WB).
  - else 00.
  - The youngest match always wins. Zeroed on bubble.
- fwd_c is registered on advance: 1 when the current EX entry has mem_write, the current MEM entry has mem_to_reg & valid & reg_write, MEM.rd == EX.rt, and ZERO_REG does not exclude rd.
- stall_cnt increments on every cycle with pc_stall=1, saturating at 2^CNT_W-1.
- Reset: all entries invalid; fwd_a=fwd_b=00; fwd_c=0; state RUN; stall_cnt=0. Combinational outputs still follow the inputs during reset, but with all entries invalid lu is 0. Reset mid-freeze or mid-LU returns to RUN the next cycle.

## Timing
- Forwarding selects have one-cycle latency: they are computed while the instruction is in ID and are valid for the whole cycle it occupies EX (and MEM, for fwd_c).
- A load-use stall is exactly 1 cycle. The dependent instruction then enters EX with fwd=01 from the load's WB stage.
- mem_busy freezes in the same cycle it is asserted. Outputs fwd_* and the entries hold for the full freeze, and resume on the first cycle mem_busy=0.
- flush with lu in the same cycle: flush wins, no stall.
- flush with mem_busy: flush is ignored. The pipeline keeps flush asserted until the freeze ends.
- Back-to-back loads feeding a consumer give one stall only.

## Structure
- Package hazard_pkg holds:
  - FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - the state enum {ST_RUN, ST_LU, ST_FREEZE}
  - the shadow-entry struct type parameterised by REG_W via localparam
- Sub-module hazard_stage_reg: one shadow entry with hold (mem_busy) and clear (bubble/rst), instantiated three times.

## Test plan
- Back-to-back dependency: ADD r3 then SUB r4,r3,r5 → fwd_a=10 in SUB's EX cycle. A further instruction using r3 one slot later → fwd_a=01.
- Load-use: LW r2 then ADD r6,r2,r7 → pc_stall=ifid_stall=idex_bubble=1 for exactly one cycle, then ADD in EX with fwd_a=01, stall_cnt=1.
- Load then store data: LW r2 then SW r2 → no stall, fwd_c=1 in SW's MEM cycle. The same sequence with ZERO_REG=1 and r0 → fwd_c=0 and fwd_a/b=00.
- Freeze: mem_busy high for 3 cycles during a pending 10-forward → stalls high, fwd_a held at 10, stall_cnt +3, forward applied after release.
- Simultaneous events: flush and lu in the same cycle → idex_bubble=1, pc_stall=0. Reset asserted in LU → next cycle state RUN, all outputs 00/0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller:
// forward select codes, FSM states and the shadow pipeline entry.
package hazard_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // Shadow entries store addresses at this width; REG_W must not exceed it
    localparam int HZ_AW = 8;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LU,
        ST_FREEZE
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [HZ_AW-1:0] rd;
        logic             reg_write;
        logic             mem_to_reg;
        logic             mem_write;
        logic [HZ_AW-1:0] rt;
    } entry_t;

    function automatic logic hz_match(
        input entry_t           e,
        input logic [HZ_AW-1:0] src,
        input logic             used,
        input logic             zero_reg
    );
        return e.valid && e.reg_write && (e.rd == src) && used
            && (!zero_reg || (src != '0));
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline entry; holds while the pipeline is frozen and
// loads with valid cleared when a bubble is inserted.
module hazard_stage_reg
    import hazard_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   hold_i,
    input  logic   clear_i,
    input  entry_t d_i,
    output entry_t q_o
);

    entry_t q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else if (!hold_i) begin
            q_q       <= d_i;
            q_q.valid <= d_i.valid & ~clear_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller with a shadow pipeline of in-flight
// destinations; forwarding selects are computed in ID and registered.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W    = 4,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_reg_write,
    input  logic             id_mem_to_reg,
    input  logic             id_mem_write,
    input  logic             flush,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             fwd_c,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic ZR = (ZERO_REG != 0);

    entry_t           sh [3];
    entry_t           id_e;
    logic [HZ_AW-1:0] rs_x, rt_x;
    logic             m_rs_ex, m_rt_ex, m_rs_mem, m_rt_mem;
    logic             lu;
    state_e           state_q, state_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic             fwd_c_q, fwd_c_d;
    logic [CNT_W-1:0] cnt_q;

    assign rs_x = HZ_AW'(id_rs);
    assign rt_x = HZ_AW'(id_rt);

    assign id_e = '{
        valid:      id_valid,
        rd:         HZ_AW'(id_rd),
        reg_write:  id_reg_write,
        mem_to_reg: id_mem_to_reg,
        mem_write:  id_mem_write,
        rt:         rt_x
    };

    hazard_stage_reg u_ex (
        .clk(clk), .rst(rst), .hold_i(mem_busy), .clear_i(idex_bubble),
        .d_i(id_e), .q_o(sh[0])
    );

    hazard_stage_reg u_mem (
        .clk(clk), .rst(rst), .hold_i(mem_busy), .clear_i(1'b0),
        .d_i(sh[0]), .q_o(sh[1])
    );

    hazard_stage_reg u_wb (
        .clk(clk), .rst(rst), .hold_i(mem_busy), .clear_i(1'b0),
        .d_i(sh[1]), .q_o(sh[2])
    );

    assign m_rs_ex  = hz_match(sh[0], rs_x, id_rs_used, ZR);
    assign m_rt_ex  = hz_match(sh[0], rt_x, id_rt_used, ZR);
    assign m_rs_mem = hz_match(sh[1], rs_x, id_rs_used, ZR);
    assign m_rt_mem = hz_match(sh[1], rt_x, id_rt_used, ZR);

    // A store whose only dependency is its data operand is covered by fwd_c
    assign lu = sh[0].mem_to_reg & (m_rs_ex | (m_rt_ex & ~id_mem_write));

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = ST_RUN;
        if (mem_busy) begin
            state_d = ST_FREEZE;
        end else begin
            unique case (state_q)
                ST_RUN:    state_d = (lu && !flush) ? ST_LU : ST_RUN;
                ST_LU:     state_d = ST_RUN;
                ST_FREEZE: state_d = ST_RUN;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_bubble = 1'b0;
        if (mem_busy) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
        end else if (flush) begin
            idex_bubble = 1'b1;
        end else if (lu) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    always_comb begin
        fwd_a_d = FWD_NONE;
        fwd_b_d = FWD_NONE;
        if (!idex_bubble) begin
            if (m_rs_ex)       fwd_a_d = FWD_MEM;
            else if (m_rs_mem) fwd_a_d = FWD_WB;
            if (m_rt_ex)       fwd_b_d = FWD_MEM;
            else if (m_rt_mem) fwd_b_d = FWD_WB;
        end
        fwd_c_d = sh[0].mem_write & sh[1].valid & sh[1].reg_write
                & sh[1].mem_to_reg & (sh[1].rd == sh[0].rt)
                & (!ZR || (sh[1].rd != '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_a_q <= FWD_NONE;
            fwd_b_q <= FWD_NONE;
            fwd_c_q <= 1'b0;
        end else if (!mem_busy) begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            fwd_c_q <= fwd_c_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (pc_stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign fwd_c     = fwd_c_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: instruction-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_rs, id_rt, id_rd;
    logic       id_rs_used, id_rt_used;
    logic       id_reg_write, id_mem_to_reg, id_mem_write;
    logic       flush, mem_busy;

    logic        pc_stall, ifid_stall, idex_bubble, fwd_c;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    logic        pc_stall2, ifid_stall2, idex_bubble2, fwd_c2;
    logic [1:0]  fwd_a2, fwd_b2;
    logic [2:0]  stall_cnt2;

    hazard_fwd_ctrl #(.REG_W(4), .ZERO_REG(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .id_mem_write(id_mem_write), .flush(flush), .mem_busy(mem_busy),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .fwd_c(fwd_c), .stall_cnt(stall_cnt)
    );

    // Narrow counter instance to reach saturation quickly
    hazard_fwd_ctrl #(.REG_W(4), .ZERO_REG(1), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .id_mem_write(id_mem_write), .flush(flush), .mem_busy(mem_busy),
        .pc_stall(pc_stall2), .ifid_stall(ifid_stall2),
        .idex_bubble(idex_bubble2), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
        .fwd_c(fwd_c2), .stall_cnt(stall_cnt2)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nbad = 0;
    bit live = 0;

    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit ld;
        bit st;
        int rt;
    } ins_t;

    // p[0] = instruction in EX, p[1] = MEM, p[2] = WB
    ins_t p [3];
    int   efa = 0, efb = 0, ecnt = 0;
    bit   efc = 0;

    function automatic bit hit(input ins_t e, input int src, input bit used);
        return e.v && e.rw && (e.rd == src) && used && (src != 0);
    endfunction

    function automatic bit lu_f();
        return p[0].ld && (hit(p[0], int'(id_rs), id_rs_used)
            || (hit(p[0], int'(id_rt), id_rt_used) && !id_mem_write));
    endfunction

    function automatic bit pcs_f();
        return mem_busy || (!flush && lu_f());
    endfunction

    function automatic bit bub_f();
        return !mem_busy && (flush || lu_f());
    endfunction

    function automatic int sel(input int src, input bit used);
        if (hit(p[0], src, used)) return 2;
        if (hit(p[1], src, used)) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) p[i] <= '{default: 0};
            efa  <= 0;
            efb  <= 0;
            efc  <= 0;
            ecnt <= 0;
        end else begin
            if (pcs_f() && ecnt < 65535) ecnt <= ecnt + 1;
            if (!mem_busy) begin
                efa <= bub_f() ? 0 : sel(int'(id_rs), id_rs_used);
                efb <= bub_f() ? 0 : sel(int'(id_rt), id_rt_used);
                efc <= p[0].st && p[1].v && p[1].rw && p[1].ld
                    && (p[1].rd == p[0].rt) && (p[1].rd != 0);
                p[2] <= p[1];
                p[1] <= p[0];
                p[0] <= '{v: id_valid && !bub_f(), rd: int'(id_rd),
                          rw: id_reg_write, ld: id_mem_to_reg,
                          st: id_mem_write, rt: int'(id_rt)};
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            check("pc_stall", 32'(pc_stall), 32'(pcs_f()));
            check("ifid_stall", 32'(ifid_stall), 32'(pcs_f()));
            check("idex_bubble", 32'(idex_bubble), 32'(bub_f()));
            check("fwd_a", 32'(fwd_a), efa);
            check("fwd_b", 32'(fwd_b), efb);
            check("fwd_c", 32'(fwd_c), 32'(efc));
            check("stall_cnt", 32'(stall_cnt), ecnt);
            check("stall_cnt_sat", 32'(stall_cnt2), (ecnt > 7) ? 7 : ecnt);
        end
    end

    task automatic put(input bit v, input int rs, input int rt, input int rd,
                       input bit ru, input bit tu, input bit rw, input bit ld,
                       input bit st, input bit fl = 0, input bit mb = 0);
        @(posedge clk);
        #1;
        id_valid      = v;
        id_rs         = rs[3:0];
        id_rt         = rt[3:0];
        id_rd         = rd[3:0];
        id_rs_used    = ru;
        id_rt_used    = tu;
        id_reg_write  = rw;
        id_mem_to_reg = ld;
        id_mem_write  = st;
        flush         = fl;
        mem_busy      = mb;
        #1;
    endtask

    task automatic nop(input bit mb = 0, input bit fl = 0);
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, fl, mb);
    endtask

    task automatic alu(input int rd, input int rs, input int rt,
                       input bit mb = 0);
        put(1, rs, rt, rd, 1, 1, 1, 0, 0, 0, mb);
    endtask

    task automatic lw(input int rd, input int rs);
        put(1, rs, 0, rd, 1, 0, 1, 1, 0);
    endtask

    task automatic sw(input int rt, input int rs);
        put(1, rs, rt, 0, 1, 1, 0, 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_used = 0; id_rt_used = 0; id_reg_write = 0;
        id_mem_to_reg = 0; id_mem_write = 0; flush = 0; mem_busy = 0;
        @(posedge clk);
        live = 1;
        #2;
        check("rst_fwd_a", 32'(fwd_a), 0);
        check("rst_fwd_c", 32'(fwd_c), 0);
        check("rst_cnt", 32'(stall_cnt), 0);
        check("rst_pc_stall", 32'(pc_stall), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ADD r3; SUB r4,r3,r5; OR r7,r3,r6
        alu(3, 1, 2);
        alu(4, 3, 5);
        check("b2b_no_stall", 32'(pc_stall), 0);
        alu(7, 3, 6);
        check("b2b_fwd_mem", 32'(fwd_a), 2);
        nop();
        check("b2b_fwd_wb", 32'(fwd_a), 1);
        nop();
        check("b2b_fwd_none", 32'(fwd_a), 0);

        // LW r2; ADD r6,r2,r7 -> one stall
        lw(2, 1);
        alu(6, 2, 7);
        check("lu_pc_stall", 32'(pc_stall), 1);
        check("lu_bubble", 32'(idex_bubble), 1);
        alu(6, 2, 7);
        check("lu_released", 32'(pc_stall), 0);
        check("lu_cnt", 32'(stall_cnt), 1);
        nop();
        check("lu_fwd_wb", 32'(fwd_a), 1);

        // LW r2; SW r2 -> no stall, store data forwarded
        lw(2, 1);
        sw(2, 1);
        check("ldst_no_stall", 32'(pc_stall), 0);
        nop();
        check("ldst_fwd_b", 32'(fwd_b), 2);
        nop();
        check("ldst_fwd_c", 32'(fwd_c), 1);

        // Same with r0: never a hazard
        lw(0, 0);
        sw(0, 0);
        check("r0_no_stall", 32'(pc_stall), 0);
        nop();
        check("r0_fwd_a", 32'(fwd_a), 0);
        check("r0_fwd_b", 32'(fwd_b), 0);
        nop();
        check("r0_fwd_c", 32'(fwd_c), 0);

        // Freeze three cycles with a pending EX/MEM forward
        alu(3, 1, 2);
        alu(4, 3, 5, 1);
        check("frz_pc_stall", 32'(pc_stall), 1);
        check("frz_no_bubble", 32'(idex_bubble), 0);
        alu(4, 3, 5, 1);
        alu(4, 3, 5, 1);
        alu(4, 3, 5);
        check("frz_cnt", 32'(stall_cnt), 4);
        nop(1);
        check("frz_fwd_applied", 32'(fwd_a), 2);
        nop(1);
        check("frz_fwd_held", 32'(fwd_a), 2);
        nop();
        check("frz_fwd_release", 32'(fwd_a), 2);
        check("frz_cnt2", 32'(stall_cnt), 6);

        // Flush with load-use: flush wins
        lw(2, 1);
        put(1, 2, 7, 6, 1, 1, 1, 0, 0, 1, 0);
        check("flush_bubble", 32'(idex_bubble), 1);
        check("flush_no_stall", 32'(pc_stall), 0);
        nop(1, 1);
        check("flush_busy_stall", 32'(pc_stall), 1);
        check("flush_busy_nobub", 32'(idex_bubble), 0);

        // Reset asserted during the LU cycle
        lw(2, 1);
        alu(6, 2, 7);
        check("lu2_stall", 32'(pc_stall), 1);
        alu(6, 2, 7);
        rst = 1'b1;
        check("lu2_cnt", 32'(stall_cnt), 8);
        check("lu2_cnt_sat", 32'(stall_cnt2), 7);
        nop();
        rst = 1'b0;
        check("rstlu_fwd_a", 32'(fwd_a), 0);
        check("rstlu_fwd_b", 32'(fwd_b), 0);
        check("rstlu_fwd_c", 32'(fwd_c), 0);
        check("rstlu_cnt", 32'(stall_cnt), 0);
        check("rstlu_pc_stall", 32'(pc_stall), 0);

        // Back-to-back loads feeding one consumer: single stall
        lw(2, 1);
        lw(3, 1);
        alu(6, 2, 3);
        check("ll_stall", 32'(pc_stall), 1);
        alu(6, 2, 3);
        check("ll_one_stall", 32'(pc_stall), 0);
        nop();
        check("ll_fwd_a", 32'(fwd_a), 0);
        check("ll_fwd_b", 32'(fwd_b), 1);
        check("ll_cnt", 32'(stall_cnt), 1);

        nop();
        nop();
        @(posedge clk);
        #1;
        live = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
